// File: rtl/demux_route4_if.sv
// Producer/consumer bundle for the 1-to-4 registered demux: one input stream
// fanning out to four independent lane handshakes.
interface demux_route4_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]   in;
  logic [1:0]         s;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] op;
  logic [3:0]         op_valid;
  logic [3:0]         op_ready;
  logic [3:0]         full;
  logic [4*CNT_W-1:0] lane_cnt;

  modport master (
    output in, s, in_valid, op_ready,
    input  in_ready, op, op_valid, full, lane_cnt
  );

  modport slave (
    input  in, s, in_valid, op_ready,
    output in_ready, op, op_valid, full, lane_cnt
  );
endinterface

// File: rtl/demux_route4.sv
// Registered 1-to-4 demux: each accepted word lands in the FIFO of lane s,
// and every lane drains through its own valid/ready handshake.
module demux_route4_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic [WIDTH-1:0] op,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty exactly.
  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;

  assign valid = (wptr != rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = valid && ready;
  assign op    = valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until the pointers advance.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wptr[AW-1:0]] <= data;
  end
endmodule

module demux_route4 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  demux_route4_if.slave  bus
);
  logic [3:0]            full_w;
  logic [3:0]            valid_w;
  logic [3:0]            push_w;
  logic [3:0][WIDTH-1:0] op_w;
  logic [3:0][CNT_W-1:0] cnt_w;

  // A full lane refuses input even if it pops this cycle: no pass-through.
  assign bus.in_ready = ~full_w[bus.s];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign push_w[k] = bus.in_valid && !full_w[k] && (bus.s == 2'(k));

    demux_route4_lane #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .push  (push_w[k]),
      .data  (bus.in),
      .ready (bus.op_ready[k]),
      .op    (op_w[k]),
      .valid (valid_w[k]),
      .full  (full_w[k]),
      .cnt   (cnt_w[k])
    );
  end

  assign bus.op       = op_w;
  assign bus.op_valid = valid_w;
  assign bus.full     = full_w;
  assign bus.lane_cnt = cnt_w;
endmodule

// File: tb/tb_demux_route4.sv
// Random + directed bench for demux_route4: per-lane expected-word queues are
// filled on accepted pushes and drained by a monitor watching the lane outputs.
module tb_demux_route4;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  demux_route4_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  demux_route4 #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;
  bit rnd_done = 0;

  logic [W-1:0] sb [4][$];
  int           cnt_m [4];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare every lane against the model, then apply this cycle's pops.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("op_valid[%0d]", k), bus.op_valid[k], sb[k].size() != 0);
        chk($sformatf("full[%0d]", k), bus.full[k], sb[k].size() == D);
        chk($sformatf("op_lane%0d", k), bus.op[k*W +: W],
            (sb[k].size() != 0) ? sb[k][0] : 0);
        chk($sformatf("lane_cnt[%0d]", k), bus.lane_cnt[k*CW +: CW], cnt_m[k]);
      end
      chk("in_ready", bus.in_ready, sb[bus.s].size() < D);
      for (int k = 0; k < 4; k++) begin
        if (!rst) begin
          sb[k].delete();
          cnt_m[k] = 0;
        end else if (bus.op_ready[k] && sb[k].size() != 0) begin
          void'(sb[k].pop_front());
        end
      end
    end
  end

  // Hold the word until accepted; the model learns of the push just after the
  // monitor has sampled the cycle, so a push is never visible in its own cycle.
  task automatic push(input logic [W-1:0] w, input logic [1:0] sel, input int budget);
    bit done = 0;
    bus.in = w;
    bus.s = sel;
    bus.in_valid = 1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (bus.in_ready) begin
        sb[sel].push_back(w);
        if (cnt_m[sel] < CMAX) cnt_m[sel]++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got=not_accepted exp=accepted lane=%0d", sel);
    end
  endtask

  task automatic wait_empty(input int budget);
    bit empty = 0;
    for (int i = 0; i < budget && !empty; i++) begin
      empty = (sb[0].size() == 0) && (sb[1].size() == 0) &&
              (sb[2].size() == 0) && (sb[3].size() == 0);
      if (!empty) begin
        @(posedge clk);
        #1;
      end
    end
    chk("drain_done", empty, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.in = 0;
    bus.s = 0;
    bus.in_valid = 0;
    bus.op_ready = 0;
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;

    // Reset then idle
    cycles(1);
    mon_en = 1;
    cycles(1);
    for (int sel = 0; sel < 4; sel++) begin
      bus.s = 2'(sel);
      #1;
      chk($sformatf("idle_in_ready_s%0d", sel), bus.in_ready, 1);
    end
    chk("idle_op", bus.op, 0);
    rst = 1;
    cycles(1);

    // Single route
    push(8'hA5, 2'd2, 10);
    chk("single_op_valid", bus.op_valid, 4'b0100);
    chk("single_op_lane2", bus.op[2*W +: W], 8'hA5);
    chk("single_cnt2", bus.lane_cnt[2*CW +: CW], 1);
    bus.op_ready = 4'hF;
    wait_empty(10);

    // Backpressure on lane 1
    bus.op_ready = 4'h0;
    push(8'h11, 2'd1, 10);
    push(8'h22, 2'd1, 10);
    chk("bp_full", bus.full, 4'b0010);
    bus.s = 2'd0;
    #1;
    chk("bp_in_ready_s0", bus.in_ready, 1);
    bus.s = 2'd1;
    #1;
    chk("bp_in_ready_s1", bus.in_ready, 0);
    fork
      push(8'h33, 2'd1, 20);
      begin
        cycles(3);
        bus.op_ready = 4'b0010;
      end
    join
    wait_empty(10);

    // Concurrent round-robin with every consumer ready
    bus.op_ready = 4'hF;
    for (int i = 0; i < 8; i++) push(8'($urandom), 2'(i % 4), 10);
    wait_empty(10);

    // Saturation on lane 3
    for (int i = 0; i < 20; i++) push(8'($urandom), 2'd3, 10);
    wait_empty(10);
    chk("sat_cnt3", bus.lane_cnt[3*CW +: CW], CMAX);

    // Reset mid-operation with lane 0 full
    bus.op_ready = 4'h0;
    push(8'hC1, 2'd0, 10);
    push(8'hC2, 2'd0, 10);
    rst = 0;
    cycles(1);
    rst = 1;
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_lane_cnt", bus.lane_cnt, 0);
    push(8'h5A, 2'd0, 10);
    chk("post_rst_lane0", bus.op[W-1:0], 8'h5A);
    bus.op_ready = 4'hF;
    wait_empty(10);

    // Random traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          push(8'($urandom), 2'($urandom_range(0, 3)), 200);
          cycles($urandom_range(0, 2));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          bus.op_ready = 4'($urandom);
          cycles(1);
        end
      end
    join
    bus.op_ready = 4'hF;
    wait_empty(20);
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
